// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the goodie/player game logic.
//   - catch_state_e : goodie_catcher FSM states (ARMED / HIT / COOLDOWN)
//   - X_W, Y_W      : screen position widths (X 11 bits, Y 10 bits)
//   - SCORE_W       : score width; SCORE_MAX is the decimal saturation ceiling
//   - bin_to_bcd2   : converts a 0..99 binary step into two packed BCD digits
// ---------------------------------------------------------------------------
package game_pkg;

  localparam int X_W       = 11;
  localparam int Y_W       = 10;
  localparam int SCORE_W   = 16;
  localparam int SCORE_MAX = 9999;
  localparam int STEP_W    = 7;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    ST_ARMED    = 2'd0,
    ST_HIT      = 2'd1,
    ST_COOLDOWN = 2'd2
  } catch_state_e;

  // Values above 99 cannot be expressed in two BCD digits; clamp them.
  function automatic logic [7:0] bin_to_bcd2(input logic [STEP_W-1:0] v);
    int n;
    n = (v > 7'd99) ? 99 : int'(v);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

endpackage

// File: rtl/score_accum.sv
// ---------------------------------------------------------------------------
// score_accum
// Saturating score accumulator. Adds `step` on each `add_pulse`.
// Build option GOODIE_SCORE_BCD_EN:
//   defined   : score is 4 packed BCD digits, decimal add, saturates at 16'h9999
//   undefined : score is binary, saturates at 16'd9999
// Ports:
//   clk        in  : system clock
//   initialize in  : synchronous active-high reset, clears score
//   add_pulse  in  : add one step this cycle
//   step       in  : points per add (1..99)
//   score      out : current score
// ---------------------------------------------------------------------------
module score_accum
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               initialize,
  input  logic               add_pulse,
  input  logic [STEP_W-1:0]  step,
  output logic [SCORE_W-1:0] score
);

  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] sat_sum;

`ifdef GOODIE_SCORE_BCD_EN
  logic [SCORE_W-1:0] addend;
  logic [SCORE_W-1:0] sum_bcd;
  logic [4:0]         dsum;
  logic               carry;

  // Ripple decimal add, digit by digit; a carry out of the thousands digit
  // means the result passed 9999 and is clamped.
  always_comb begin
    addend  = {8'h00, bin_to_bcd2(step)};
    sum_bcd = '0;
    carry   = 1'b0;
    dsum    = '0;
    for (int i = 0; i < 4; i++) begin
      dsum = {1'b0, score_q[4*i +: 4]} + {1'b0, addend[4*i +: 4]} + {4'b0, carry};
      if (dsum > 5'd9) begin
        sum_bcd[4*i +: 4] = 4'(dsum - 5'd10);
        carry             = 1'b1;
      end else begin
        sum_bcd[4*i +: 4] = dsum[3:0];
        carry             = 1'b0;
      end
    end
    sat_sum = carry ? 16'h9999 : sum_bcd;
  end
`else
  logic [SCORE_W:0] sum_bin;

  always_comb begin
    sum_bin = {1'b0, score_q} + (SCORE_W+1)'(step);
    sat_sum = (sum_bin > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                   : sum_bin[SCORE_W-1:0];
  end
`endif

  always_comb begin
    score_d = score_q;
    if (add_pulse) score_d = sat_sum;
  end

  always_ff @(posedge clk) begin
    if (initialize) score_q <= '0;
    else            score_q <= score_d;
  end

  assign score = score_q;

endmodule

// File: rtl/goodie_catcher.sv
// ---------------------------------------------------------------------------
// goodie_catcher
// Samples goodie and player positions once per frame, tests bounding-box
// overlap, and on an accepted catch emits a one-cycle collect/respawn pulse,
// bumps a saturating score and holds off further catches for a cooldown.
// Build option GOODIE_SCORE_BCD_EN selects a BCD score (see score_accum).
// Ports:
//   clk            in  : system clock
//   initialize     in  : synchronous active-high reset
//   frame_tick     in  : one-cycle sample strobe per frame
//   enable         in  : game running; gates new catches in ARMED
//   goodie_x/_y    in  : goodie top-left position
//   player_x/_y    in  : player top-left position
//   collect        out : one-cycle pulse per accepted catch
//   goodie_respawn out : same pulse, feeds the goodie mover's initialize
//   score          out : running score
//   cooldown       out : high while catches are being ignored
// Latency: tick in n -> samples n+1 -> hit_q n+2 -> collect n+3 -> score n+4.
// ---------------------------------------------------------------------------
module goodie_catcher
  import game_pkg::*;
#(
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int GOODIE_W        = 20,
  parameter int GOODIE_H        = 20,
  parameter int PLAYER_W        = 40,
  parameter int PLAYER_H        = 30,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int SCORE_STEP      = 1
) (
  input  logic               clk,
  input  logic               initialize,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic [X_W-1:0]     goodie_x,
  input  logic [Y_W-1:0]     goodie_y,
  input  logic [X_W-1:0]     player_x,
  input  logic [Y_W-1:0]     player_y,
  output logic               collect,
  output logic               goodie_respawn,
  output logic [SCORE_W-1:0] score,
  output logic               cooldown
);

  // Stage 1: frame sample
  logic [X_W-1:0] gx_q, gx_d, px_q, px_d;
  logic [Y_W-1:0] gy_q, gy_d, py_q, py_d;
  logic           s1_vld_q, s1_vld_d;

  // Stage 2: overlap result
  logic           hit_q, hit_d;

  // FSM and cooldown counter
  catch_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [X_W:0]   gx_ext, px_ext;
  logic [Y_W:0]   gy_ext, py_ext;
  logic           ov_x, ov_y, on_screen;
  logic           hit_pulse;

  // NOTE: every always_comb output gets a default first, so no path through
  // the block can leave a signal unassigned and infer a latch.
  always_comb begin
    gx_d = gx_q;
    gy_d = gy_q;
    px_d = px_q;
    py_d = py_q;
    if (frame_tick) begin
      gx_d = goodie_x;
      gy_d = goodie_y;
      px_d = player_x;
      py_d = player_y;
    end
    // A sample may only score if it was taken while ARMED. This keeps the
    // tick that counts the cooldown down to zero from scoring on its own,
    // so the first scoring sample is the one after the last cooldown tick.
    s1_vld_d = frame_tick && (state_q == ST_ARMED);
  end

  // One extra bit on every sum so player_x+PLAYER_W etc. cannot wrap.
  always_comb begin
    gx_ext    = {1'b0, gx_q};
    px_ext    = {1'b0, px_q};
    gy_ext    = {1'b0, gy_q};
    py_ext    = {1'b0, py_q};
    ov_x      = (gx_ext < px_ext + (X_W+1)'(PLAYER_W)) &&
                (px_ext < gx_ext + (X_W+1)'(GOODIE_W));
    ov_y      = (gy_ext < py_ext + (Y_W+1)'(PLAYER_H)) &&
                (py_ext < gy_ext + (Y_W+1)'(GOODIE_H));
    // An underflowed goodie X shows up as a huge value and fails this test.
    on_screen = (gx_q < X_W'(SCREEN_W)) && (gy_q < Y_W'(SCREEN_H));
    hit_d     = s1_vld_q && ov_x && ov_y && on_screen;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_ARMED: begin
        if (hit_q && enable) state_d = ST_HIT;
      end
      ST_HIT: begin
        cnt_d   = CNT_W'(COOLDOWN_FRAMES);
        state_d = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (cnt_q == '0)     state_d = ST_ARMED;
        else if (frame_tick) cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_ARMED;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, independent of order.
  always_ff @(posedge clk) begin
    if (initialize) begin
      gx_q     <= '0;
      gy_q     <= '0;
      px_q     <= '0;
      py_q     <= '0;
      s1_vld_q <= 1'b0;
      hit_q    <= 1'b0;
      state_q  <= ST_ARMED;
      cnt_q    <= '0;
    end else begin
      gx_q     <= gx_d;
      gy_q     <= gy_d;
      px_q     <= px_d;
      py_q     <= py_d;
      s1_vld_q <= s1_vld_d;
      hit_q    <= hit_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  assign hit_pulse      = (state_q == ST_HIT);
  assign collect        = hit_pulse;
  assign goodie_respawn = hit_pulse;
  assign cooldown       = (state_q == ST_COOLDOWN);

  score_accum u_score (
    .clk        (clk),
    .initialize (initialize),
    .add_pulse  (hit_pulse),
    .step       (STEP_W'(SCORE_STEP)),
    .score      (score)
  );

endmodule

// File: tb/tb_goodie_catcher.sv
// ---------------------------------------------------------------------------
// tb_goodie_catcher
// Directed, table-driven bench for goodie_catcher, plus hand-written
// sequences for exact latency, cooldown, reset and score saturation.
// A second instance (SCORE_STEP=99, COOLDOWN_FRAMES=1) reaches saturation.
// ---------------------------------------------------------------------------
module tb_goodie_catcher;
  import game_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               initialize = 1'b1;
  logic               frame_tick = 1'b0;
  logic               enable     = 1'b1;
  logic [X_W-1:0]     goodie_x   = '0;
  logic [Y_W-1:0]     goodie_y   = '0;
  logic [X_W-1:0]     player_x   = '0;
  logic [Y_W-1:0]     player_y   = '0;
  logic               collect, goodie_respawn, cooldown;
  logic [SCORE_W-1:0] score;

  logic               init2 = 1'b1;
  logic               tick2 = 1'b0;
  logic               collect2, respawn2, cooldown2;
  logic [SCORE_W-1:0] score2;

  goodie_catcher dut (
    .clk(clk), .initialize(initialize), .frame_tick(frame_tick), .enable(enable),
    .goodie_x(goodie_x), .goodie_y(goodie_y), .player_x(player_x), .player_y(player_y),
    .collect(collect), .goodie_respawn(goodie_respawn), .score(score), .cooldown(cooldown)
  );

  goodie_catcher #(.COOLDOWN_FRAMES(1), .SCORE_STEP(99)) dut_sat (
    .clk(clk), .initialize(init2), .frame_tick(tick2), .enable(1'b1),
    .goodie_x(11'd110), .goodie_y(10'd210), .player_x(11'd100), .player_y(10'd200),
    .collect(collect2), .goodie_respawn(respawn2), .score(score2), .cooldown(cooldown2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  int resp_err  = 0;
  int cyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (collect) pulse_cnt <= pulse_cnt + 1;
    if (collect !== goodie_respawn || collect2 !== respawn2) resp_err <= resp_err + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [15:0] exp_score(input int v);
`ifdef GOODIE_SCORE_BCD_EN
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
`else
    return 16'(v);
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk) initialize = 1'b1;
    @(negedge clk);
    @(negedge clk) initialize = 1'b0;
  endtask

  // One tick with the given positions, then watch long enough for collect.
  task automatic tick_window(input logic [X_W-1:0] gx, input logic [Y_W-1:0] gy,
                             input logic [X_W-1:0] px, input logic [Y_W-1:0] py,
                             input logic en, output int hits);
    int base;
    @(negedge clk);
    goodie_x = gx; goodie_y = gy; player_x = px; player_y = py; enable = en;
    frame_tick = 1'b1;
    base = pulse_cnt;
    @(negedge clk) frame_tick = 1'b0;
    repeat (5) @(negedge clk);
    hits = pulse_cnt - base;
  endtask

  typedef struct {
    logic [X_W-1:0] gx;
    logic [Y_W-1:0] gy;
    logic [X_W-1:0] px;
    logic [Y_W-1:0] py;
    logic           en;
    int             exp_hits;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int hits;
    int catch_ticks[$];
    int c2;

    vecs[0]  = '{11'd110,  10'd210, 11'd100, 10'd200, 1'b1, 1}; // plain overlap
    vecs[1]  = '{11'd140,  10'd210, 11'd100, 10'd200, 1'b1, 0}; // right edge touch
    vecs[2]  = '{11'd139,  10'd210, 11'd100, 10'd200, 1'b1, 1};
    vecs[3]  = '{11'd80,   10'd210, 11'd100, 10'd200, 1'b1, 0}; // left edge touch
    vecs[4]  = '{11'd81,   10'd210, 11'd100, 10'd200, 1'b1, 1};
    vecs[5]  = '{11'd110,  10'd180, 11'd100, 10'd200, 1'b1, 0}; // top edge touch
    vecs[6]  = '{11'd110,  10'd181, 11'd100, 10'd200, 1'b1, 1};
    vecs[7]  = '{11'd110,  10'd230, 11'd100, 10'd200, 1'b1, 0}; // bottom edge touch
    vecs[8]  = '{11'd110,  10'd229, 11'd100, 10'd200, 1'b1, 1};
    vecs[9]  = '{11'd2040, 10'd210, 11'd0,   10'd200, 1'b1, 0}; // wrapped X
    vecs[10] = '{11'd110,  10'd500, 11'd100, 10'd200, 1'b1, 0}; // Y off-screen
    vecs[11] = '{11'd639,  10'd210, 11'd630, 10'd200, 1'b1, 1}; // last visible X
    vecs[12] = '{11'd640,  10'd210, 11'd630, 10'd200, 1'b1, 0}; // forced: X off
    vecs[13] = '{11'd110,  10'd479, 11'd100, 10'd470, 1'b1, 1}; // last visible Y
    vecs[14] = '{11'd110,  10'd480, 11'd100, 10'd470, 1'b1, 0}; // forced: Y off
    vecs[15] = '{11'd110,  10'd210, 11'd100, 10'd200, 1'b0, 0}; // disabled

    // Reset state
    do_reset();
    @(negedge clk) init2 = 1'b0;
    check("rst_collect",  32'(collect), 0);
    check("rst_respawn",  32'(goodie_respawn), 0);
    check("rst_cooldown", 32'(cooldown), 0);
    check("rst_score",    32'(score), 0);

    // Exact latency: tick in cycle 10, collect only in 13, score in 14
    goodie_x = 11'd110; goodie_y = 10'd210; player_x = 11'd100; player_y = 10'd200;
    while (cyc < 10) @(negedge clk);
    frame_tick = 1'b1;                                 // cycle n
    @(negedge clk) frame_tick = 1'b0;                  // n+1
    check("lat_n1_collect", 32'(collect), 0);
    @(negedge clk);                                    // n+2
    check("lat_n2_collect", 32'(collect), 0);
    @(negedge clk);                                    // n+3
    check("lat_n3_collect", 32'(collect), 1);
    check("lat_n3_respawn", 32'(goodie_respawn), 1);
    check("lat_n3_score",   32'(score), 0);
    @(negedge clk);                                    // n+4
    check("lat_n4_collect", 32'(collect), 0);
    check("lat_n4_score",   32'(score), 32'(exp_score(1)));
    check("lat_n4_cooldown", 32'(cooldown), 1);

    // Table-driven overlap/boundary vectors, each from a fresh reset
    for (int i = 0; i < 16; i++) begin
      do_reset();
      tick_window(vecs[i].gx, vecs[i].gy, vecs[i].px, vecs[i].py, vecs[i].en, hits);
      check($sformatf("vec%0d_hits", i), 32'(hits), 32'(vecs[i].exp_hits));
      check($sformatf("vec%0d_score", i), 32'(score), 32'(exp_score(vecs[i].exp_hits)));
    end
    enable = 1'b1;

    // Cooldown: 40 overlapping ticks 4 cycles apart -> catches on ticks 1 and 32
    do_reset();
    goodie_x = 11'd110; goodie_y = 10'd210; player_x = 11'd100; player_y = 10'd200;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
      if (collect) catch_ticks.push_back(k);
      if (k == 10) check("cd_mid_cooldown", 32'(cooldown), 1);
    end
    repeat (2) @(negedge clk);
    check("cd_catch_count", 32'(catch_ticks.size()), 2);
    if (catch_ticks.size() == 2) begin
      check("cd_first_tick",  32'(catch_ticks[0]), 1);
      check("cd_second_tick", 32'(catch_ticks[1]), 32);
    end
    check("cd_score", 32'(score), 32'(exp_score(2)));

    // Reset in cycle n+2 after an overlapping tick discards the catch
    do_reset();
    @(negedge clk) frame_tick = 1'b1;                  // n
    @(negedge clk) frame_tick = 1'b0;                  // n+1
    @(negedge clk) initialize = 1'b1;                  // n+2
    @(negedge clk) initialize = 1'b0;                  // n+3
    check("midrst_n3_collect", 32'(collect), 0);
    @(negedge clk);                                    // n+4
    check("midrst_n4_collect",  32'(collect), 0);
    check("midrst_score",       32'(score), 0);
    check("midrst_cooldown",    32'(cooldown), 0);
    // Still ARMED: the next overlapping tick scores
    tick_window(11'd110, 10'd210, 11'd100, 10'd200, 1'b1, hits);
    check("midrst_rearm_hits", 32'(hits), 1);

    // Reset and tick in the same cycle: sample dropped
    do_reset();
    @(negedge clk);
    frame_tick = 1'b1; initialize = 1'b1;
    begin
      int base;
      base = pulse_cnt;
      @(negedge clk) begin frame_tick = 1'b0; initialize = 1'b0; end
      repeat (5) @(negedge clk);
      check("same_cycle_rst_hits", 32'(pulse_cnt - base), 0);
    end

    // Saturation on the step-99 instance: catch, then one cooldown tick
    c2 = 0;
    for (int i = 1; i <= 102; i++) begin
      @(negedge clk) tick2 = 1'b1;
      @(negedge clk) tick2 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      if (collect2) c2++;
      if (i == 102) check("sat_collect_at_max", 32'(collect2), 1);
      @(negedge clk) tick2 = 1'b1;
      @(negedge clk) tick2 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      if (i == 100) check("sat_score_9900", 32'(score2), 32'(exp_score(9900)));
      if (i == 101) check("sat_score_9999", 32'(score2), 32'(exp_score(9999)));
      if (i == 102) check("sat_score_hold", 32'(score2), 32'(exp_score(9999)));
    end
    check("sat_catch_count", 32'(c2), 102);

    check("respawn_matches_collect", 32'(resp_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
